// File: rtl/audio_tx_pkg.sv
// Shared types and helpers for the I2S audio transmitter.
// Holds the controller state enum and the sample saturation function.
package audio_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Clamp a signed value to the signed range of an abits-wide sample.
  // The result is returned sign-extended; callers keep the low abits.
  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int unsigned        abits
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (abits - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (abits - 32'd1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Signal bundle between the stereo FIFO pair / I2S pins and the transmitter.
// master = FIFO side and pin observer, slave = transmitter.
interface audio_i2s_tx_if #(
  parameter int DATA_WIDTH = 32
);
  import audio_tx_pkg::*;

  logic [DATA_WIDTH-1:0] left_dout;
  logic                  left_empty;
  logic                  left_rd_en;
  logic [DATA_WIDTH-1:0] right_dout;
  logic                  right_empty;
  logic                  right_rd_en;
  logic                  i2s_bclk;
  logic                  i2s_lrclk;
  logic                  i2s_sdata;
  logic                  underflow;

  modport master (
    output left_dout, left_empty,
    output right_dout, right_empty,
    input  left_rd_en, right_rd_en,
    input  i2s_bclk, i2s_lrclk,
    input  i2s_sdata, underflow
  );

  modport slave (
    input  left_dout, left_empty,
    input  right_dout, right_empty,
    output left_rd_en, right_rd_en,
    output i2s_bclk, i2s_lrclk,
    output i2s_sdata, underflow
  );

endinterface

// File: rtl/i2s_clk_div.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clocks while enabled.
// Ports: clk_i, rst_i, en_i (run), bclk_o (registered), fall_tick_o.
module i2s_clk_div #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic bclk_o,
  output logic fall_tick_o
);
  import audio_tx_pkg::*;

  localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bclk_q, bclk_d;
  logic          wrap;

  assign wrap = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  // High in the cycle whose closing edge drives bclk 1->0.
  assign fall_tick_o = wrap && bclk_q;
  assign bclk_o      = bclk_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter fed by two show-ahead FIFOs, zero-fill on underflow.
// Ports: clock/reset, left/right FIFO read side, I2S pins, underflow pulse.
module audio_i2s_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int AUDIO_BITS = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] left_dout,
  input  logic                  left_empty,
  output logic                  left_rd_en,
  input  logic [DATA_WIDTH-1:0] right_dout,
  input  logic                  right_empty,
  output logic                  right_rd_en,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  underflow
);
  import audio_tx_pkg::*;

  localparam int SW = 2 * AUDIO_BITS;
  localparam int KW = (SW > 1) ? $clog2(SW) : 1;
  localparam logic [KW-1:0] KMAX  = KW'(SW - 1);
  localparam logic [KW-1:0] LR_LO = KW'(AUDIO_BITS - 1);
  localparam logic [KW-1:0] LR_HI = KW'(SW - 2);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [SW-1:0]   sh_q, sh_d;
  logic            sd_q, sd_d;
  logic            lr_q, lr_d;
  logic            lrd_q, lrd_d;
  logic            rrd_q, rrd_d;
  logic            uf_q, uf_d;
  logic            load;
  logic            have;
  logic            fall_tick;
  logic [AUDIO_BITS-1:0] lsat;
  logic [AUDIO_BITS-1:0] rsat;

  i2s_clk_div #(
    .BCLK_DIV(BCLK_DIV)
  ) u_div (
    .clk_i      (clock),
    .rst_i      (reset),
    .en_i       (state_q == RUN),
    .bclk_o     (i2s_bclk),
    .fall_tick_o(fall_tick)
  );

  assign have = !left_empty && !right_empty;
  assign lsat = AUDIO_BITS'(sat(64'($signed(left_dout)), AUDIO_BITS));
  assign rsat = AUDIO_BITS'(sat(64'($signed(right_dout)), AUDIO_BITS));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sh_d    = sh_q;
    sd_d    = sd_q;
    lr_d    = lr_q;
    lrd_d   = 1'b0;
    rrd_d   = 1'b0;
    uf_d    = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (have) begin
          state_d = RUN;
          k_d     = '0;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (fall_tick) begin
          k_d  = (k_q == KMAX) ? '0 : k_q + K_ONE;
          load = (k_q == KMAX);
          sh_d = sh_q << 1;
          sd_d = sh_q[SW-2];
          lr_d = (k_d >= LR_LO) && (k_d <= LR_HI);
        end
      end
      default: ;
    endcase
    // A frame is only taken when both sides have a word, so the
    // left/right pairing survives an underflow on either FIFO.
    if (load) begin
      if (have) begin
        lrd_d = 1'b1;
        rrd_d = 1'b1;
        sh_d  = {lsat, rsat};
      end else begin
        sh_d = '0;
        uf_d = 1'b1;
      end
      sd_d = sh_d[SW-1];
      lr_d = (k_d >= LR_LO) && (k_d <= LR_HI);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      sh_q    <= '0;
      sd_q    <= 1'b0;
      lr_q    <= 1'b0;
      lrd_q   <= 1'b0;
      rrd_q   <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sh_q    <= sh_d;
      sd_q    <= sd_d;
      lr_q    <= lr_d;
      lrd_q   <= lrd_d;
      rrd_q   <= rrd_d;
      uf_q    <= uf_d;
    end
  end

  assign i2s_sdata   = sd_q;
  assign i2s_lrclk   = lr_q;
  assign left_rd_en  = lrd_q;
  assign right_rd_en = rrd_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx (AUDIO_BITS=16, BCLK_DIV=2).
// Reference predicts every output from elapsed cycles since start.
module tb_audio_i2s_tx;
  localparam int DW    = 32;
  localparam int AB    = 16;
  localparam int DIV   = 2;
  localparam int FRAME = 2 * DIV * 2 * AB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  audio_i2s_tx_if #(.DATA_WIDTH(DW)) bus ();

  audio_i2s_tx #(
    .DATA_WIDTH(DW),
    .AUDIO_BITS(AB),
    .BCLK_DIV  (DIV)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .left_dout  (bus.left_dout),
    .left_empty (bus.left_empty),
    .left_rd_en (bus.left_rd_en),
    .right_dout (bus.right_dout),
    .right_empty(bus.right_empty),
    .right_rd_en(bus.right_rd_en),
    .i2s_bclk   (bus.i2s_bclk),
    .i2s_lrclk  (bus.i2s_lrclk),
    .i2s_sdata  (bus.i2s_sdata),
    .underflow  (bus.underflow)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] lq[$];
  logic [31:0] rq[$];
  bit          cap[$];
  bit          lrcap[$];

  bit            running = 0;
  int            n = 0;
  logic [2*AB-1:0] frame = '0;
  bit            fpop = 0;
  logic [5:0]    exp_v = '0;
  logic          prev_lrd = 0;
  logic          prev_rrd = 0;
  logic          prev_bclk = 0;
  int lpops = 0, rpops = 0, ufs = 0;
  int cyc_cnt = 0, last_rise = -1, bad_period = 0, rises = 0;

  function automatic logic [5:0] outs();
    return {bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata,
            bus.left_rd_en, bus.right_rd_en, bus.underflow};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic logic [AB-1:0] sat(input logic [31:0] w);
    longint v, hi, lo;
    v  = $signed(w);
    hi = (longint'(1) << (AB - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return AB'(v);
  endfunction

  function automatic logic [31:0] rword();
    case ($urandom % 3)
      0: return $urandom;
      1: return 32'($urandom_range(0, 65535)) - 32'd32768;
      default: begin
        case ($urandom % 4)
          0: return 32'd32767;
          1: return 32'd32768;
          2: return 32'hFFFF8000;
          default: return 32'hFFFF7FFF;
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] capword(input bit use_lr);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (use_lr) w = {w[30:0], (i < lrcap.size()) ? lrcap[i] : 1'b0};
      else        w = {w[30:0], (i < cap.size()) ? cap[i] : 1'b0};
    end
    return w;
  endfunction

  task automatic drive();
    bus.left_empty  = (lq.size() == 0);
    bus.right_empty = (rq.size() == 0);
    bus.left_dout   = (lq.size() == 0) ? $urandom : lq[0];
    bus.right_dout  = (rq.size() == 0) ? $urandom : rq[0];
  endtask

  task automatic load_frame();
    if (lq.size() > 0 && rq.size() > 0) begin
      frame = {sat(lq[0]), sat(rq[0])};
      fpop  = 1;
    end else begin
      frame = '0;
      fpop  = 0;
    end
  endtask

  // Expected outputs for the cycle following the coming clock edge.
  task automatic predict();
    int  k;
    logic eb, el, es, er;
    if (rst) begin
      running = 0;
      exp_v   = '0;
      return;
    end
    if (!running) begin
      if (lq.size() > 0 && rq.size() > 0) begin
        running = 1;
        n = 0;
        load_frame();
      end else begin
        exp_v = '0;
        return;
      end
    end else begin
      n++;
      if (n % FRAME == 0) load_frame();
    end
    k  = (n / (2 * DIV)) % (2 * AB);
    eb = ((n / DIV) % 2) == 1;
    el = (k >= AB - 1) && (k <= 2 * AB - 2);
    es = frame[2*AB-1-k];
    er = (n % FRAME) == 0;
    exp_v = {eb, el, es, er && fpop, er && fpop, er && !fpop};
  endtask

  task automatic step();
    logic [5:0] o;
    @(negedge clk);
    cyc_cnt++;
    o = outs();
    chk("cycle_outputs", 64'(o), 64'(exp_v));
    if (prev_lrd) begin
      if (lq.size() > 0) void'(lq.pop_front());
      lpops++;
    end
    if (prev_rrd) begin
      if (rq.size() > 0) void'(rq.pop_front());
      rpops++;
    end
    prev_lrd = o[2];
    prev_rrd = o[1];
    if (o[0]) ufs++;
    if (o[5] && !prev_bclk) begin
      cap.push_back(o[3]);
      lrcap.push_back(o[4]);
      rises++;
      if (last_rise >= 0 && cyc_cnt - last_rise != 2 * DIV) bad_period++;
      last_rise = cyc_cnt;
    end
    prev_bclk = o[5];
  endtask

  task automatic cyc(input bit pl, input bit pr,
                     input logic [31:0] lv, input logic [31:0] rv);
    step();
    if (pl) lq.push_back(lv);
    if (pr) rq.push_back(rv);
    drive();
    predict();
  endtask

  task automatic run_until(input int target, input int budget, input bit feed);
    int i;
    i = 0;
    while (!(running && n == target) && i < budget) begin
      if (feed) cyc(lq.size() < 2, rq.size() < 2, rword(), rword());
      else      cyc(0, 0, '0, '0);
      i++;
    end
    chk("reach_n", 64'(running && n == target), 64'd1);
  endtask

  task automatic do_reset(input bit clear);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 64'(outs()), 64'd0);
    running  = 0;
    exp_v    = '0;
    prev_lrd = 0;
    prev_rrd = 0;
    if (clear) begin
      lq.delete();
      rq.delete();
      lpops = 0;
      rpops = 0;
      ufs   = 0;
      rises = 0;
      bad_period = 0;
    end
    cap.delete();
    lrcap.delete();
    drive();
    cyc(0, 0, '0, '0);
    cyc(0, 0, '0, '0);
    rst = 1'b0;
    last_rise = -1;
    predict();
  endtask

  initial begin
    drive();
    #1;
    chk("reset_state", 64'(outs()), 64'd0);
    repeat (3) cyc(0, 0, '0, '0);
    rst = 1'b0;
    predict();
    repeat (5) cyc(0, 0, '0, '0);
    chk("idle_quiet", 64'(outs()), 64'd0);

    // Basic frame and lrclk lead
    cyc(1, 1, 32'h0000_1234, 32'hFFFF_ABCD);
    run_until(FRAME + 1, FRAME + 20, 0);
    chk("cap_len", 64'(cap.size() >= 32), 64'd1);
    chk("left_slot", 64'(capword(0) >> 16), 64'h1234);
    chk("right_slot", 64'(capword(0) & 32'hFFFF), 64'hABCD);
    chk("lrclk_pattern", 64'(capword(1)), 64'h0001_FFFE);
    chk("pops_left_1", 64'(lpops), 64'd1);
    chk("pops_right_1", 64'(rpops), 64'd1);
    chk("underflow_1", 64'(ufs), 64'd1);

    // Saturation
    do_reset(1);
    cyc(1, 1, 32'h0001_2345, 32'hFFFE_0000);
    run_until(FRAME + 1, FRAME + 20, 0);
    chk("sat_high", 64'(capword(0) >> 16), 64'h7FFF);
    chk("sat_low", 64'(capword(0) & 32'hFFFF), 64'h8000);

    // Three preloaded pairs then starvation
    do_reset(1);
    repeat (3) cyc(1, 1, rword(), rword());
    run_until(6 * FRAME - 1, 6 * FRAME + 20, 0);
    chk("pops_left_3", 64'(lpops), 64'd3);
    chk("pops_right_3", 64'(rpops), 64'd3);
    chk("underflows_3", 64'(ufs), 64'd3);

    // Unbalanced FIFOs keep pairing
    do_reset(1);
    cyc(1, 1, rword(), rword());
    cyc(1, 0, rword(), '0);
    run_until(3 * FRAME - 1, 3 * FRAME + 20, 0);
    chk("unbal_pops_l", 64'(lpops), 64'd1);
    chk("unbal_pops_r", 64'(rpops), 64'd1);
    chk("unbal_uf", 64'(ufs), 64'd2);
    chk("left_left", 64'(lq.size()), 64'd1);

    // Reset mid-frame at k=20
    do_reset(1);
    cyc(1, 1, 32'h0000_4321, 32'hFFFF_8765);
    cyc(1, 1, 32'h0000_0F0F, 32'h0000_7000);
    run_until(81, 120, 0);
    do_reset(0);
    run_until(FRAME + 1, FRAME + 20, 0);
    chk("restart_frame", 64'(capword(0)), 64'h0F0F_7000);
    chk("restart_pops_l", 64'(lpops), 64'd2);
    chk("restart_pops_r", 64'(rpops), 64'd2);
    chk("restart_empty", 64'(lq.size()), 64'd0);

    // 100 frames of continuous data
    do_reset(1);
    run_until(100 * FRAME - 1, 100 * FRAME + 50, 1);
    chk("stream_pops_l", 64'(lpops), 64'd100);
    chk("stream_pops_r", 64'(rpops), 64'd100);
    chk("stream_uf", 64'(ufs), 64'd0);
    chk("bclk_period", 64'(bad_period), 64'd0);
    chk("bclk_rises", 64'(rises), 64'd3200);

    repeat (4) cyc(0, 0, '0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 The parameters SHALL be: DATA_WIDTH, default 32, FIFO word width (signed two's complement); AUDIO_BITS, default 16, serial bits per channel slot; BCLK_DIV, default 4, clocks per half bit-clock period (minimum 1).
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; its ports SHALL be, in order:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- left_dout  in  DATA_WIDTH  head word of the left FIFO
- left_empty  in  1  left FIFO empty
- left_rd_en  out  1  pops the left FIFO
- right_dout  in  DATA_WIDTH  head word of the right FIFO
- right_empty  in  1  right FIFO empty
- right_rd_en  out  1  pops the right FIFO
- i2s_bclk  out  1  serial bit clock
- i2s_lrclk  out  1  word select (0 = left, 1 = right)
- i2s_sdata  out  1  serial data, MSB first
- underflow  out  1  one-cycle pulse per zero-filled frame

Function
REQ-003 The FIFO read interface SHALL be show-ahead: dout is valid whenever empty=0, and rd_en=1 for one clock pops one word.
REQ-004 States SHALL be IDLE and RUN; in IDLE, i2s_bclk, i2s_lrclk and i2s_sdata SHALL be held at 0 and no rd_en SHALL be asserted.
REQ-005 IDLE SHALL go to RUN in the first cycle with left_empty=0 and right_empty=0; that cycle is a frame load (REQ-009); RUN SHALL be left only by reset.
REQ-006 In RUN, a divider SHALL count 0..BCLK_DIV-1 and toggle i2s_bclk on each wrap; the divider SHALL restart at 0 on IDLE->RUN, so the first rising edge follows BCLK_DIV clocks later.
REQ-007 A falling tick (i2s_bclk toggling 1->0) SHALL advance bit index k, 0..2*AUDIO_BITS-1, with wrap; i2s_sdata and i2s_lrclk SHALL change only on falling ticks or on a frame load.
REQ-008 i2s_sdata SHALL be bit (AUDIO_BITS-1-k) of left for k<AUDIO_BITS, else bit (2*AUDIO_BITS-1-k) of right; i2s_lrclk SHALL be 1 for k in AUDIO_BITS-1..2*AUDIO_BITS-2, else 0, so it leads data by one bclk period.
REQ-009 A frame load SHALL occur on IDLE->RUN and on each falling tick where k wraps to 0; if both FIFOs are non-empty, left_rd_en and right_rd_en SHALL both be 1 for exactly that cycle and the 2*AUDIO_BITS shift register SHALL load {sat(left_dout), sat(right_dout)}.
REQ-010 If either FIFO is empty at a frame load, neither FIFO SHALL be popped, the frame SHALL carry all zeros, and underflow SHALL pulse for one cycle; this keeps left/right pairing.
REQ-011 sat() SHALL clamp the signed DATA_WIDTH value to the signed AUDIO_BITS range: values above 2^(AUDIO_BITS-1)-1 give 0x7FFF, values below -2^(AUDIO_BITS-1) give 0x8000 (16-bit case), and all other values pass through unchanged.
REQ-012 The rd_en outputs SHALL never be asserted outside frame-load cycles; at most one pop per FIFO per frame.
REQ-013 All outputs SHALL be registered; the first MSB SHALL appear on i2s_sdata one clock after the IDLE->RUN cycle.

Reset
REQ-014 Reset SHALL force IDLE, clear the divider, k and the shift register, and drive all outputs to 0, asynchronously.
REQ-015 Reset asserted mid-frame SHALL abandon the frame with no further pops; after release, the block SHALL re-enter via REQ-005.

Structure
REQ-016 A package audio_tx_pkg SHALL hold the IDLE/RUN state enum and the saturation function.
REQ-017 The bclk divider and tick generation SHALL be one sub-module, i2s_clk_div, which outputs i2s_bclk plus a one-cycle fall_tick.

Verification (AUDIO_BITS=16, BCLK_DIV=2, frame = 128 clocks)
REQ-018 Write L=0x00001234 and R=0xFFFFABCD, then capture on bclk rising edges -> left slot 0x1234, right slot 0xABCD, one pop each, lrclk toggling one bclk ahead of the MSB.
REQ-019 L=0x00012345 and R=0xFFFE0000 -> slots 0x7FFF and 0x8000.
REQ-020 Preload 3 pairs, then stop writing -> 3 frames of data, then zero frames with one underflow pulse per frame and no rd_en.
REQ-021 Left holds 2 words, right holds 1 word -> 1 frame of data, then underflow, and left still holds 1 word.
REQ-022 Assert reset at k=20 -> all outputs 0 within the same cycle; after release with data present, a clean new frame starting at k=0.
REQ-023 Supply data continuously for 100 frames -> exactly 100 pops per FIFO, bclk period exactly 4 clocks, and no underflow.
